kuznechik_arbiter: RTL and testbench
====================================

KUZNECHIK_ARBITER -- requirements
Module: kuznechik_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: WAIT-state watchdog limit in cycles; used only when KUZ_ARB_TIMEOUT_EN is defined.
REQ-002 clk_i  in  1  single clock; all logic on its rising edge.
REQ-003 resetn_i  in  1  asynchronous, active-low reset.
REQ-004 ch_req_i  in  2  per-channel encryption request, level, bit k = channel k.
REQ-005 ch_data_i  in  256  plaintext; channel 0 on [127:0], channel 1 on [255:128].
REQ-006 ch_ack_i  in  2  per-channel result acknowledge.
REQ-007 ch_busy_o  out  2  channel k owns the core, from grant until result acknowledged.
REQ-008 ch_valid_o  out  2  result valid for channel k; one-hot or zero.
REQ-009 ch_data_o  out  128  ciphertext, qualified by ch_valid_o.
REQ-010 ch_err_o  out  1  result is a timeout error; tied 0 without KUZ_ARB_TIMEOUT_EN.
REQ-011 core_request_o  out  1  request to the cipher core.
REQ-012 core_ack_o  out  1  result acknowledge to the cipher core.
REQ-013 core_data_o  out  128  plaintext to the cipher core.
REQ-014 core_busy_i, core_valid_i  in  1 each  cipher core status.
REQ-015 core_data_i  in  128  ciphertext from the cipher core.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DELIVER.
REQ-017 IDLE: when core_busy_i=0 and any ch_req_i bit is high, grant one channel, latch its ch_data_i into core_data_o, set its ch_busy_o bit, and go to ISSUE.
REQ-018 Round-robin: if both channels request, grant the channel not granted last; after reset, channel 0 wins.
REQ-019 ISSUE: core_request_o=1 for exactly this one cycle, then go to WAIT.
REQ-020 WAIT: on core_valid_i=1, capture core_data_i into ch_data_o, set ch_valid_o[grant], pulse core_ack_o for one cycle, and go to DELIVER.
REQ-021 DELIVER: hold ch_valid_o and ch_data_o stable until ch_ack_i[grant]=1; on that edge clear ch_valid_o, ch_busy_o and ch_err_o, record grant as last, and go to IDLE.
REQ-022 Latency: grant-to-core_request_o is 1 cycle; core_valid_i-to-ch_valid_o is 1 cycle; ack-to-next-grant is at least 1 cycle.
REQ-023 Requests from a non-granted channel are held pending, not dropped; ch_ack_i on a non-granted channel is ignored.
REQ-024 ch_ack_i arriving together with ch_valid_o rise has no effect; only an ack sampled while ch_valid_o is high completes the transfer.
REQ-025 core_valid_i outside WAIT is ignored; core_ack_o stays 0.

Reset
REQ-026 Asynchronous assertion forces state IDLE, last grant to channel 1 (so channel 0 wins first), and all outputs to 0, including core_data_o and ch_data_o.
REQ-027 Reset mid-transfer abandons the transfer; no ch_valid_o is produced for it after reset release.

Configuration
REQ-028 Macro KUZ_ARB_TIMEOUT_EN defined: an 8+ bit counter clears on entry to WAIT and increments every WAIT cycle; at TIMEOUT_CYCLES without core_valid_i, go to DELIVER with ch_data_o=0, ch_err_o=1 and core_ack_o=0.
REQ-029 Macro not defined: no counter; WAIT waits indefinitely; ch_err_o is constant 0.

Structure
REQ-030 Shared package kuznechik_pkg holds BLOCK_W=128, N_CH=2, the FSM state encoding, and the default TIMEOUT_CYCLES.
REQ-031 One sub-module, kuz_rr_arbiter, computes the 2-way round-robin grant from the request vector and the last grant; the FSM stays in kuznechik_arbiter.

Verification
REQ-032 Ch0 requests 1122334455667700ffeeddccbbaa9988 -> core_data_o equals it; ch_valid_o=01; ch_data_o=7f679d90bebc24305a468d42b9d4edcd.
REQ-033 Both channels request in the same cycle twice in a row -> grant order ch0, ch1, ch0; each ch_valid_o stays high until its own ack.
REQ-034 Ch1 ack withheld 10 cycles -> ch_valid_o=10 and ch_data_o stable for 10 cycles; ch0 request meanwhile stays pending and is granted 1 cycle after the ack.
REQ-035 resetn_i pulsed low in WAIT -> all outputs 0 immediately; later core_valid_i=1 produces no ch_valid_o.
REQ-036 KUZ_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=20 and core_valid_i held 0 -> after 20 WAIT cycles ch_valid_o=01, ch_err_o=1, ch_data_o=0.

Source files
------------

// File: rtl/kuznechik_pkg.sv
// Shared definitions for the Kuznechik channel arbiter.
package kuznechik_pkg;

   localparam int unsigned BLOCK_W            = 128;
   localparam int unsigned N_CH               = 2;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

   typedef logic [BLOCK_W-1:0] block_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DELIVER = 2'd3
   } arb_state_e;

   // One-hot channel mask from a channel index.
   function automatic logic [N_CH-1:0] ch_onehot(input logic idx);
      logic [N_CH-1:0] mask;
      mask      = '0;
      mask[idx] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/kuz_rr_arbiter.sv
// Two-way round-robin grant: on contention the channel not granted last wins.
module kuz_rr_arbiter
   import kuznechik_pkg::*;
(
   input  logic [N_CH-1:0] req,
   input  logic            last_grant,
   output logic            grant_c,
   output logic            any_c
);

   // Pure combinational grant selection.
   always_comb begin
      any_c   = |req;
      grant_c = 1'b0;
      if (req[0] && req[1]) begin
         grant_c = ~last_grant;
      end else begin
         grant_c = req[1];
      end
   end

endmodule

// File: rtl/kuznechik_arbiter.sv
// Shares one Kuznechik cipher core between two request channels.
// Optional WAIT watchdog enabled by defining KUZ_ARB_TIMEOUT_EN.
module kuznechik_arbiter
   import kuznechik_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
   input  logic                    clk_i,
   input  logic                    resetn_i,
   input  logic [N_CH-1:0]         ch_req_i,
   input  logic [N_CH*BLOCK_W-1:0] ch_data_i,
   input  logic [N_CH-1:0]         ch_ack_i,
   output logic [N_CH-1:0]         ch_busy_o,
   output logic [N_CH-1:0]         ch_valid_o,
   output logic [BLOCK_W-1:0]      ch_data_o,
   output logic                    ch_err_o,
   output logic                    core_request_o,
   output logic                    core_ack_o,
   output logic [BLOCK_W-1:0]      core_data_o,
   input  logic                    core_busy_i,
   input  logic                    core_valid_i,
   input  logic [BLOCK_W-1:0]      core_data_i
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

   arb_state_e      state_q, state_d;
   logic            grant_q, grant_d;
   logic            last_q, last_d;
   logic [N_CH-1:0] busy_d, valid_d;
   block_t          ch_data_d, core_data_d;
   logic            core_req_d, core_ack_d;
   logic            grant_c, req_any_c;
   block_t          sel_data_c;

`ifdef KUZ_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             timeout_c;

   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign ch_err_o  = err_q;
`else
   assign ch_err_o  = 1'b0;
`endif

   kuz_rr_arbiter u_rr (
      .req        (ch_req_i),
      .last_grant (last_q),
      .grant_c    (grant_c),
      .any_c      (req_any_c)
   );

   assign sel_data_c = grant_c ? ch_data_i[2*BLOCK_W-1:BLOCK_W] : ch_data_i[BLOCK_W-1:0];

   // State and output registers; reset leaves channel 1 as last so channel 0 wins first.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q        <= ST_IDLE;
         grant_q        <= 1'b0;
         last_q         <= 1'b1;
         ch_busy_o      <= '0;
         ch_valid_o     <= '0;
         ch_data_o      <= '0;
         core_request_o <= 1'b0;
         core_ack_o     <= 1'b0;
         core_data_o    <= '0;
`ifdef KUZ_ARB_TIMEOUT_EN
         cnt_q          <= '0;
         err_q          <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_q         <= last_d;
         ch_busy_o      <= busy_d;
         ch_valid_o     <= valid_d;
         ch_data_o      <= ch_data_d;
         core_request_o <= core_req_d;
         core_ack_o     <= core_ack_d;
         core_data_o    <= core_data_d;
`ifdef KUZ_ARB_TIMEOUT_EN
         cnt_q          <= cnt_d;
         err_q          <= err_d;
`endif
      end
   end

   // Next-state and next-output logic; request/ack strobes default low.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      busy_d      = ch_busy_o;
      valid_d     = ch_valid_o;
      ch_data_d   = ch_data_o;
      core_req_d  = 1'b0;
      core_ack_d  = 1'b0;
      core_data_d = core_data_o;
`ifdef KUZ_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!core_busy_i && req_any_c) begin
               grant_d     = grant_c;
               core_data_d = sel_data_c;
               busy_d      = ch_onehot(grant_c);
               core_req_d  = 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef KUZ_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT: begin
            if (core_valid_i) begin
               ch_data_d  = core_data_i;
               valid_d    = ch_onehot(grant_q);
               core_ack_d = 1'b1;
               state_d    = ST_DELIVER;
            end
`ifdef KUZ_ARB_TIMEOUT_EN
            else if (timeout_c) begin
               ch_data_d = '0;
               valid_d   = ch_onehot(grant_q);
               err_d     = 1'b1;
               state_d   = ST_DELIVER;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_DELIVER: begin
            if (ch_ack_i[grant_q] && ch_valid_o[grant_q]) begin
               valid_d = '0;
               busy_d  = '0;
               last_d  = grant_q;
               state_d = ST_IDLE;
`ifdef KUZ_ARB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_kuznechik_arbiter.sv
// Self-checking bench for kuznechik_arbiter with a queue-based channel/core model.
module tb_kuznechik_arbiter;

`ifdef KUZ_ARB_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 20;
`else
   localparam int unsigned TB_TIMEOUT = 255;
`endif

   localparam logic [127:0] KV_PT = 128'h1122334455667700ffeeddccbbaa9988;
   localparam logic [127:0] KV_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

   logic         clk_i = 1'b0;
   logic         resetn_i = 1'b1;
   logic [1:0]   ch_req_i = '0;
   logic [255:0] ch_data_i = '0;
   logic [1:0]   ch_ack_i = '0;
   logic [1:0]   ch_busy_o, ch_valid_o;
   logic [127:0] ch_data_o, core_data_o;
   logic         ch_err_o, core_request_o, core_ack_o;
   logic         core_busy_i = 1'b0;
   logic         core_valid_i = 1'b0;
   logic [127:0] core_data_i = '0;

   int errors = 0;
   int checks = 0;
   int last_ch = 1;
   logic [127:0] q0[$];
   logic [127:0] q1[$];

   kuznechik_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk_i          (clk_i),
      .resetn_i       (resetn_i),
      .ch_req_i       (ch_req_i),
      .ch_data_i      (ch_data_i),
      .ch_ack_i       (ch_ack_i),
      .ch_busy_o      (ch_busy_o),
      .ch_valid_o     (ch_valid_o),
      .ch_data_o      (ch_data_o),
      .ch_err_o       (ch_err_o),
      .core_request_o (core_request_o),
      .core_ack_o     (core_ack_o),
      .core_data_o    (core_data_o),
      .core_busy_i    (core_busy_i),
      .core_valid_i   (core_valid_i),
      .core_data_i    (core_data_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Behavioural cipher core: known answer for the reference vector, a fixed mix otherwise.
   function automatic logic [127:0] core_fn(input logic [127:0] pt);
      if (pt == KV_PT) return KV_CT;
      return pt ^ {pt[63:0], pt[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Channel request level follows "has a block queued"; data is the queue head.
   task automatic drive_reqs();
      ch_req_i[0] = (q0.size() != 0);
      ch_req_i[1] = (q1.size() != 0);
      ch_data_i[127:0]   = (q0.size() != 0) ? q0[0] : '0;
      ch_data_i[255:128] = (q1.size() != 0) ? q1[0] : '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  128'(ch_busy_o), '0);
      check({tag, "_valid"}, 128'(ch_valid_o), '0);
      check({tag, "_cdata"}, ch_data_o, '0);
      check({tag, "_err"},   128'(ch_err_o), '0);
      check({tag, "_creq"},  128'(core_request_o), '0);
      check({tag, "_cack"},  128'(core_ack_o), '0);
      check({tag, "_kdata"}, core_data_o, '0);
   endtask

   task automatic wait_core_request();
      int n = 0;
      while (core_request_o !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("core_request_seen", 128'(core_request_o), 128'(1));
   endtask

   // One complete transfer checked against the round-robin / queue model.
   task automatic serve_one(input int hold, input bit early_ack);
      int          exp_ch, lat;
      logic [1:0]  oh;
      logic [127:0] pt, ct;
      bit          p0, p1;
      p0 = (q0.size() != 0);
      p1 = (q1.size() != 0);
      exp_ch = (p0 && p1) ? 1 - last_ch : (p0 ? 0 : 1);
      oh = (exp_ch == 0) ? 2'b01 : 2'b10;
      pt = (exp_ch == 0) ? q0[0] : q1[0];
      ct = core_fn(pt);
      wait_core_request();
      check("grant_busy", 128'(ch_busy_o), 128'(oh));
      check("core_data", core_data_o, pt);
      if (exp_ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      drive_reqs();
      tick();
      check("issue_single", 128'(core_request_o), '0);
      lat = $urandom_range(0, 3);
      repeat (lat) begin
         ch_ack_i = ~oh & 2'($urandom);
         tick();
         check("wait_valid", 128'(ch_valid_o), '0);
      end
      ch_ack_i     = early_ack ? oh : 2'b00;
      core_valid_i = 1'b1;
      core_data_i  = ct;
      tick();
      core_valid_i = 1'b0;
      core_data_i  = rnd128();
      ch_ack_i     = 2'b00;
      check("valid_rise", 128'(ch_valid_o), 128'(oh));
      check("result_data", ch_data_o, ct);
      check("core_ack_pulse", 128'(core_ack_o), 128'(1));
      check("err_clear", 128'(ch_err_o), '0);
      for (int i = 0; i < hold; i++) begin
         ch_ack_i     = ~oh & 2'($urandom);
         core_valid_i = 1'($urandom);
         core_data_i  = rnd128();
         tick();
         check("hold_valid", 128'(ch_valid_o), 128'(oh));
         check("hold_data", ch_data_o, ct);
         check("hold_cack", 128'(core_ack_o), '0);
      end
      core_valid_i = 1'b0;
      ch_ack_i = oh;
      tick();
      ch_ack_i = 2'b00;
      check("done_valid", 128'(ch_valid_o), '0);
      check("done_busy", 128'(ch_busy_o), '0);
      last_ch = exp_ch;
   endtask

   task automatic do_reset();
      resetn_i = 1'b0;
      #3;
      check_all_zero("reset");
      @(negedge clk_i);
      resetn_i = 1'b1;
      last_ch = 1;
      #1;
   endtask

   initial begin
      #3;
      do_reset();

      // Known-answer transfer on channel 0.
      q0.push_back(KV_PT);
      drive_reqs();
      serve_one(2, 1'b0);

      // core_valid_i while idle is ignored.
      core_valid_i = 1'b1;
      core_data_i  = rnd128();
      repeat (3) begin
         tick();
         check("idle_valid", 128'(ch_valid_o), '0);
         check("idle_cack", 128'(core_ack_o), '0);
      end
      core_valid_i = 1'b0;

      // Contention twice in a row: order ch0, ch1, ch0.
      do_reset();
      q0.push_back(rnd128());
      q0.push_back(rnd128());
      q1.push_back(rnd128());
      drive_reqs();
      serve_one(3, 1'b1);
      serve_one(1, 1'b0);
      serve_one(2, 1'b1);

      // Ch1 wins (ch0 was last), its ack is withheld 10 cycles while ch0 waits.
      q1.push_back(rnd128());
      q0.push_back(rnd128());
      drive_reqs();
      serve_one(10, 1'b0);
      tick();
      check("pending_grant_busy", 128'(ch_busy_o), 128'(2'b01));
      check("pending_grant_req", 128'(core_request_o), 128'(1));
      serve_one(1, 1'b0);

      // Core busy holds off the grant.
      core_busy_i = 1'b1;
      q1.push_back(rnd128());
      drive_reqs();
      repeat (3) begin
         tick();
         check("core_busy_hold", 128'(ch_busy_o), '0);
      end
      core_busy_i = 1'b0;
      serve_one(1, 1'b0);

      // Randomised traffic.
      for (int it = 0; it < 30; it++) begin
         int n0, n1;
         n0 = $urandom_range(0, 2);
         n1 = $urandom_range(0, 2);
         if (n0 + n1 == 0) n0 = 1;
         for (int k = 0; k < n0; k++) q0.push_back(rnd128());
         for (int k = 0; k < n1; k++) q1.push_back(rnd128());
         drive_reqs();
         while (q0.size() + q1.size() != 0) serve_one($urandom_range(0, 4), 1'($urandom));
      end

      // Reset in WAIT abandons the transfer.
      q0.push_back(rnd128());
      drive_reqs();
      wait_core_request();
      tick();
      tick();
      #2;
      resetn_i = 1'b0;
      #1;
      check_all_zero("midreset");
      q0.delete();
      drive_reqs();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      resetn_i = 1'b1;
      last_ch = 1;
      core_valid_i = 1'b1;
      core_data_i  = rnd128();
      repeat (3) begin
         tick();
         check("abandoned_valid", 128'(ch_valid_o), '0);
         check("abandoned_cack", 128'(core_ack_o), '0);
      end
      core_valid_i = 1'b0;

`ifdef KUZ_ARB_TIMEOUT_EN
      // Watchdog: core never answers.
      begin
         int n = 0;
         q0.push_back(rnd128());
         drive_reqs();
         wait_core_request();
         void'(q0.pop_front());
         drive_reqs();
         while (ch_valid_o == 2'b00 && n < 100) begin
            tick();
            n++;
         end
         check("timeout_cycles", 128'(n), 128'(TB_TIMEOUT + 1));
         check("timeout_valid", 128'(ch_valid_o), 128'(2'b01));
         check("timeout_err", 128'(ch_err_o), 128'(1));
         check("timeout_data", ch_data_o, '0);
         check("timeout_cack", 128'(core_ack_o), '0);
         ch_ack_i = 2'b01;
         tick();
         ch_ack_i = 2'b00;
         check("timeout_err_clr", 128'(ch_err_o), '0);
         check("timeout_valid_clr", 128'(ch_valid_o), '0);
         last_ch = 0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
